// File: rtl/hazard_forward_ctrl.sv
// EX-stage forwarding select generation, load-use stall and branch flush control.
// Tracks {valid, rd, reg_write, mem_read} for the EX, MEM and WB pipeline slots.
module hazard_forward_ctrl #(
   parameter int REG_ADDR_W = 5
) (
   input  logic                  CLK,
   input  logic                  RESET,
   input  logic                  ID_VALID,
   input  logic [REG_ADDR_W-1:0] ID_RS1,
   input  logic [REG_ADDR_W-1:0] ID_RS2,
   input  logic [REG_ADDR_W-1:0] ID_RD,
   input  logic                  ID_REG_WRITE,
   input  logic                  ID_MEM_READ,
   input  logic                  BRANCH_TAKEN,
   input  logic                  BUSYWAIT,
   output logic [1:0]            FWD_A_SEL,
   output logic [1:0]            FWD_B_SEL,
   output logic                  STALL,
   output logic                  FLUSH,
   output logic                  EX_VALID
);

   typedef struct packed {
      logic                  valid;
      logic [REG_ADDR_W-1:0] rd;
      logic                  reg_write;
      logic                  mem_read;
   } slot_t;

   localparam logic [1:0] SEL_REGFILE = 2'b00;
   localparam logic [1:0] SEL_EX_MEM  = 2'b01;
   localparam logic [1:0] SEL_MEM_WB  = 2'b10;

   slot_t ex_q, ex_d;
   slot_t mem_q, mem_d;
   slot_t wb_q, wb_d;
   logic [1:0][1:0] sel_q, sel_d;
   logic [1:0][1:0] sel_new;
   logic [1:0][REG_ADDR_W-1:0] id_rs;
   logic lu_hit;
   logic wb_trace_unused;

   function automatic logic produces(input slot_t p, input logic [REG_ADDR_W-1:0] rs);
      return p.valid & p.reg_write & (p.rd != '0) & (p.rd == rs);
   endfunction

   assign id_rs = {ID_RS2, ID_RS1};

   // The EX producer lands in MEM and the MEM producer in WB while the consumer is in EX;
   // checking EX first makes the youngest producer win.
   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_sel
         assign sel_new[gi] = !ID_VALID                 ? SEL_REGFILE :
                              produces(ex_q, id_rs[gi])  ? SEL_EX_MEM  :
                              produces(mem_q, id_rs[gi]) ? SEL_MEM_WB  :
                                                           SEL_REGFILE;
      end
   endgenerate

   always_comb begin
      lu_hit = ID_VALID & ex_q.mem_read &
               (produces(ex_q, ID_RS1) | produces(ex_q, ID_RS2));
      STALL  = lu_hit & ~BRANCH_TAKEN & ~BUSYWAIT;
      FLUSH  = BRANCH_TAKEN & ~BUSYWAIT;

      ex_d  = ex_q;
      mem_d = mem_q;
      wb_d  = wb_q;
      sel_d = sel_q;
      if (!BUSYWAIT) begin
         wb_d  = mem_q;
         mem_d = ex_q;
         if (BRANCH_TAKEN || STALL) begin
            ex_d  = '0;
            sel_d = '0;
         end else begin
            ex_d  = {ID_VALID, ID_RD, ID_REG_WRITE, ID_MEM_READ};
            sel_d = sel_new;
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         ex_q  <= '0;
         mem_q <= '0;
         wb_q  <= '0;
         sel_q <= '0;
      end else begin
         ex_q  <= ex_d;
         mem_q <= mem_d;
         wb_q  <= wb_d;
         sel_q <= sel_d;
      end
   end

   // WB never forwards (regfile writes before read); kept only for trace visibility.
   assign wb_trace_unused = ^wb_q;

   assign FWD_A_SEL = sel_q[0];
   assign FWD_B_SEL = sel_q[1];
   assign EX_VALID  = ex_q.valid;

endmodule

// File: tb/tb_hazard_forward_ctrl.sv
// Table-driven bench for hazard_forward_ctrl: combinational STALL/FLUSH checked before each
// edge, registered outputs expected via a scoreboard queue and checked after the edge.
module tb_hazard_forward_ctrl;

   logic       clk;
   logic       rst;
   logic       id_valid;
   logic [4:0] id_rs1, id_rs2, id_rd;
   logic       id_reg_write, id_mem_read, branch_taken, busywait;
   logic [1:0] fwd_a_sel, fwd_b_sel;
   logic       stall, flush, ex_valid;

   int checks   = 0;
   int failures = 0;

   hazard_forward_ctrl #(.REG_ADDR_W(5)) dut (
      .CLK(clk),
      .RESET(rst),
      .ID_VALID(id_valid),
      .ID_RS1(id_rs1),
      .ID_RS2(id_rs2),
      .ID_RD(id_rd),
      .ID_REG_WRITE(id_reg_write),
      .ID_MEM_READ(id_mem_read),
      .BRANCH_TAKEN(branch_taken),
      .BUSYWAIT(busywait),
      .FWD_A_SEL(fwd_a_sel),
      .FWD_B_SEL(fwd_b_sel),
      .STALL(stall),
      .FLUSH(flush),
      .EX_VALID(ex_valid)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   typedef struct {
      logic       rst;
      logic       idv;
      logic [4:0] rs1;
      logic [4:0] rs2;
      logic [4:0] rd;
      logic       rw;
      logic       mr;
      logic       br;
      logic       bw;
      logic       chk_comb;
      logic       stall;
      logic       flush;
      logic [1:0] a;
      logic [1:0] b;
      logic       exv;
   } vec_t;

   typedef struct {
      int         idx;
      logic [1:0] a;
      logic [1:0] b;
      logic       exv;
   } exp_t;

   localparam int NVEC = 26;
   vec_t vecs [NVEC];
   exp_t sb_q [$];

   function automatic vec_t mk(input logic r, input logic iv, input int s1, input int s2,
                               input int d, input logic w, input logic m, input logic b_t,
                               input logic b_w, input logic cc, input logic st,
                               input logic fl, input int ea, input int eb, input logic ev);
      vec_t v;
      v.rst = r;  v.idv = iv;
      v.rs1 = 5'(s1); v.rs2 = 5'(s2); v.rd = 5'(d);
      v.rw = w;   v.mr = m;  v.br = b_t; v.bw = b_w;
      v.chk_comb = cc; v.stall = st; v.flush = fl;
      v.a = 2'(ea); v.b = 2'(eb); v.exv = ev;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, req);
      end
   endtask

   task automatic drive(input vec_t v);
      rst          = v.rst;
      id_valid     = v.idv;
      id_rs1       = v.rs1;
      id_rs2       = v.rs2;
      id_rd        = v.rd;
      id_reg_write = v.rw;
      id_mem_read  = v.mr;
      branch_taken = v.br;
      busywait     = v.bw;
   endtask

   task automatic step(input int idx, input vec_t v);
      exp_t e;
      drive(v);
      #1;
      if (v.chk_comb) begin
         chk($sformatf("v%0d_stall", idx), {7'd0, stall}, {7'd0, v.stall});
         chk($sformatf("v%0d_flush", idx), {7'd0, flush}, {7'd0, v.flush});
      end
      e.idx = idx; e.a = v.a; e.b = v.b; e.exv = v.exv;
      sb_q.push_back(e);
      @(posedge clk);
      #1;
      e = sb_q.pop_front();
      chk($sformatf("v%0d_fwd_a", e.idx), {6'd0, fwd_a_sel}, {6'd0, e.a});
      chk($sformatf("v%0d_fwd_b", e.idx), {6'd0, fwd_b_sel}, {6'd0, e.b});
      chk($sformatf("v%0d_ex_valid", e.idx), {7'd0, ex_valid}, {7'd0, e.exv});
      $display("vec %0d rst=%0b rs1=%0d rs2=%0d rd=%0d br=%0b bw=%0b -> a=%0b b=%0b exv=%0b",
               idx, v.rst, v.rs1, v.rs2, v.rd, v.br, v.bw, fwd_a_sel, fwd_b_sel, ex_valid);
   endtask

   initial begin
      int stall_cnt;
      //            rst iv rs1 rs2 rd rw mr br bw  cc st fl  a  b  exv
      vecs[0]  = mk(1, 0,  0,  0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0);
      vecs[1]  = mk(1, 0,  0,  0, 0, 0, 0, 0, 0,  1, 0, 0, 0, 0, 0);
      // back-to-back RAW
      vecs[2]  = mk(0, 1,  1,  2, 5, 1, 0, 0, 0,  1, 0, 0, 0, 0, 1);
      vecs[3]  = mk(0, 1,  5,  5, 6, 1, 0, 0, 0,  1, 0, 0, 1, 1, 1);
      // freeze: inputs would otherwise give a=10 b=00
      vecs[4]  = mk(0, 1,  5,  0, 9, 1, 0, 0, 1,  1, 0, 0, 1, 1, 1);
      vecs[5]  = mk(0, 1,  5,  0, 9, 1, 0, 1, 1,  1, 0, 0, 1, 1, 1);
      vecs[6]  = mk(0, 1,  5,  0, 9, 1, 0, 0, 1,  1, 0, 0, 1, 1, 1);
      vecs[7]  = mk(0, 1,  5,  6, 7, 1, 0, 0, 0,  1, 0, 0, 2, 1, 1);
      // distance-2 RAW with an rd=0 producer in flight
      vecs[8]  = mk(0, 1,  1,  2, 0, 1, 0, 0, 0,  1, 0, 0, 0, 0, 1);
      vecs[9]  = mk(0, 1,  0,  7, 8, 1, 0, 0, 0,  1, 0, 0, 0, 2, 1);
      // load-use
      vecs[10] = mk(0, 1,  1,  2, 3, 1, 1, 0, 0,  1, 0, 0, 0, 0, 1);
      vecs[11] = mk(0, 1,  3,  4, 9, 1, 0, 0, 0,  1, 1, 0, 0, 0, 0);
      vecs[12] = mk(0, 1,  3,  4, 9, 1, 0, 0, 0,  1, 0, 0, 2, 0, 1);
      // load to x0 never stalls
      vecs[13] = mk(0, 1,  1,  2, 0, 1, 1, 0, 0,  1, 0, 0, 0, 0, 1);
      vecs[14] = mk(0, 1,  0,  0,10, 1, 0, 0, 0,  1, 0, 0, 0, 0, 1);
      // branch flush, including a flush that overrides a load-use
      vecs[15] = mk(0, 1, 10,  1,11, 1, 0, 1, 0,  1, 0, 1, 0, 0, 0);
      vecs[16] = mk(0, 1,  1,  2,12, 1, 1, 0, 0,  1, 0, 0, 0, 0, 1);
      vecs[17] = mk(0, 1,  5, 12,13, 1, 0, 1, 0,  1, 0, 1, 0, 0, 0);
      // ID bubble forces 00; invalid / non-writing producers never forward
      vecs[18] = mk(0, 0, 12, 12,14, 1, 0, 0, 0,  1, 0, 0, 0, 0, 0);
      vecs[19] = mk(0, 1, 14, 12,15, 1, 0, 0, 0,  1, 0, 0, 0, 0, 1);
      vecs[20] = mk(0, 1, 15, 15,16, 0, 0, 0, 0,  1, 0, 0, 1, 1, 1);
      vecs[21] = mk(0, 1, 16, 15,17, 1, 0, 0, 0,  1, 0, 0, 0, 2, 1);
      // reset during freeze with a pending load-use
      vecs[22] = mk(0, 1, 17, 17,20, 1, 1, 0, 0,  1, 0, 0, 1, 1, 1);
      vecs[23] = mk(0, 1, 20, 20,21, 1, 0, 0, 1,  1, 0, 0, 1, 1, 1);
      vecs[24] = mk(1, 1, 20, 20,21, 1, 0, 1, 1,  1, 0, 0, 0, 0, 0);
      vecs[25] = mk(0, 1, 20, 20, 1, 1, 0, 0, 0,  1, 0, 0, 0, 0, 1);

      for (int i = 0; i < NVEC; i++) step(i, vecs[i]);

      // Load-use stall lasts exactly one cycle while the consumer is held in ID.
      step(NVEC, mk(0, 1, 0, 0, 3, 1, 1, 0, 0, 1, 0, 0, 0, 0, 1));
      stall_cnt = 0;
      for (int i = 0; i < 4; i++) begin
         drive(mk(0, 1, 3, 0, 4, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
         #1;
         if (stall === 1'b1) stall_cnt++;
         @(posedge clk);
         #1;
         if (i == 0) chk("lu_bubble_ex_valid", {7'd0, ex_valid}, 8'd0);
         if (i == 1) chk("lu_fwd_a_after_stall", {6'd0, fwd_a_sel}, 8'd2);
         $display("lu cycle %0d stall_cnt=%0d a=%0b exv=%0b", i, stall_cnt, fwd_a_sel, ex_valid);
      end
      chk("lu_stall_cycles", 8'(stall_cnt), 8'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
